mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//  Multi-cycle sequencer for RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) issued from EX.
//  Accepts an op when EX decodes ALUOp=2'b10 with Funct7=7'b0000001 and runs a radix-2 shift-add /
//  restoring-divide loop. Holds the pipeline stalled until the result is ready, then returns one
//  XLEN-bit result for the EX result mux. The single-cycle ALU path is untouched.
// PARAMETERS
//  XLEN   32  operand/result width; iteration count equals XLEN
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rst_n      in   1     synchronous reset, active-low
//  start_i    in   1     EX holds a valid M-extension op (level, held while stalled)
//  funct3_i   in   3     op select: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  op_a_i     in   XLEN  rs1 value (forwarded)
//  op_b_i     in   XLEN  rs2 value (forwarded)
//  flush_i    in   1     EX flush (branch/jump redirect); aborts any op in progress
//  stall_o    out  1     freeze IF/ID/EX and bubble MEM while the op is outstanding
//  busy_o     out  1     state != IDLE
//  done_o     out  1     one-cycle pulse: result_o valid, EX may advance this cycle
//  result_o   out  XLEN  result; holds last value until the next done_o
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, stall_o=0, busy_o=0, done_o=0, result_o=0, internals=0.
//  FSM: IDLE -> PREP -> CALC -> FIN -> IDLE.
//   IDLE: if start_i && !flush_i, latch funct3/operands -> PREP. Otherwise stay.
//   PREP: one cycle. Take magnitudes per signedness (MULH/DIV/REM: both signed; MULHSU: rs1 signed).
//         Record result sign. Detect special cases and go straight to FIN; else clear cnt -> CALC.
//   CALC: exactly XLEN cycles, cnt 0..XLEN-1. Mul uses 2*XLEN accumulator, shift-add by one bit/cycle.
//         Div uses restoring step on {rem,quot}, one quotient bit/cycle. At cnt==XLEN-1 -> FIN.
//   FIN: apply sign correction, drive result_o, done_o=1, stall_o=0 -> IDLE.
//  Latency: start sampled in cycle T -> done_o at T+XLEN+2 (T+34 for XLEN=32). Special cases finish at T+2.
//  stall_o = (IDLE && start_i && !flush_i) || PREP || CALC. stall_o is 0 in FIN, so EX retires that cycle.
//  start_i is ignored outside IDLE, including FIN. The instruction just retired cannot restart.
//  Result select: MUL=prod[XLEN-1:0]; MULH/MULHSU/MULHU=prod[2XLEN-1:XLEN] after sign fix;
//   DIV/DIVU=quotient; REM/REMU=remainder. Remainder sign follows dividend; quotient negated if signs differ.
//  Special cases (RISC-V spec, no trap):
//   Divide by zero: DIV/DIVU -> all-ones; REM/REMU -> op_a.
//   Signed overflow (-2^(XLEN-1) / -1): DIV -> -2^(XLEN-1); REM -> 0.
//   MUL by zero is not special and takes the full loop.
//  flush_i=1 in any non-IDLE state: -> IDLE next cycle, no done_o, result_o unchanged.
//   flush_i wins over start_i in IDLE.
//  rst_n=0 mid-operation: immediate return to reset values at that edge; no done_o.
//  Operands are captured at start; later changes to op_a_i/op_b_i have no effect on the op in flight.
// TESTING
//  1. MUL 7*-3 (funct3=000): stall_o high T..T+33, done_o at T+34, result 0xFFFFFFEB.
//  2. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU 100/7 -> 2, all at T+34.
//  4. DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same -> 0; each done_o at T+2.
//  5. Start MUL, flush_i at T+10: busy_o=0 at T+11, no done_o. A new DIVU issued at T+12 completes at T+46.
//  6. rst_n low at T+20 of a DIV: all outputs 0 next cycle. start_i held through FIN restarts nothing.
//     Back-to-back ops each take the full latency.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one result bit per CALC cycle.
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;
  state_t state, state_nxt;

  logic [2:0]             f3_q;
  logic signed [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0]        mcand_q;
  logic [2*XLEN-1:0]      acc_q;
  logic [CW-1:0]          cnt_q;
  logic                   neg_q, nrem_q, spec_q;
  logic [XLEN-1:0]        res_q;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_w(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Operand decode: signedness, magnitudes and RISC-V special cases
  logic            is_div, sgn_a, sgn_b, a_neg, b_neg, div0, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_val;

  always_comb begin
    is_div   = f3_q[2];
    sgn_a    = is_div ? !f3_q[0] : (f3_q[1:0] != 2'b11);
    sgn_b    = is_div ? !f3_q[0] : !f3_q[1];
    a_neg    = sgn_a & a_q[XLEN-1];
    b_neg    = sgn_b & b_q[XLEN-1];
    a_mag    = cond_neg(a_q, a_neg);
    b_mag    = cond_neg(b_q, b_neg);
    div0     = (b_q == '0);
    ovf      = !f3_q[0] && (a_q == SMIN) && (b_q == '1);
    special  = is_div && (div0 || ovf);
    spec_val = div0 ? (f3_q[1] ? a_q : '1) : (f3_q[1] ? '0 : SMIN);
  end

  // Iteration step: shift-add multiply and restoring divide share acc_q
  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN-1:0]   div_sub;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_nxt, div_nxt;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
    div_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge  = (div_sh >= {1'b0, mcand_q});
    div_sub = div_sh[XLEN-1:0] - mcand_q;
    div_nxt = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                     : {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // Final sign correction and result select
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fin_val;

  always_comb begin
    prod_fix = cond_neg_w(acc_q, neg_q);
    fin_val  = '0;
    if (spec_q) begin
      fin_val = acc_q[XLEN-1:0];
    end else begin
      case (f3_q)
        3'b000:                fin_val = prod_fix[XLEN-1:0];
        3'b001, 3'b010, 3'b011: fin_val = prod_fix[2*XLEN-1:XLEN];
        3'b100, 3'b101:        fin_val = cond_neg(acc_q[XLEN-1:0], neg_q);
        default:               fin_val = cond_neg(acc_q[2*XLEN-1:XLEN], nrem_q);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    busy_o    = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_i && !flush_i) begin
          state_nxt = PREP;
          stall_o   = 1'b1;
        end
      end
      PREP: begin
        stall_o = 1'b1;
        if (flush_i)      state_nxt = IDLE;
        else if (special) state_nxt = FIN;
        else              state_nxt = CALC;
      end
      CALC: begin
        stall_o = 1'b1;
        if (flush_i)             state_nxt = IDLE;
        else if (cnt_q == LAST)  state_nxt = FIN;
      end
      FIN: begin
        state_nxt = IDLE;
        done_o    = !flush_i;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign result_o = done_o ? fin_val : res_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      nrem_q  <= 1'b0;
      spec_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            f3_q <= funct3_i;
            a_q  <= op_a_i;
            b_q  <= op_b_i;
          end
        end
        PREP: begin
          cnt_q  <= '0;
          spec_q <= special;
          neg_q  <= a_neg ^ b_neg;
          nrem_q <= a_neg;
          if (special) begin
            acc_q <= {{XLEN{1'b0}}, spec_val};
          end else if (is_div) begin
            acc_q   <= {{XLEN{1'b0}}, a_mag};
            mcand_q <= b_mag;
          end else begin
            acc_q   <= {{XLEN{1'b0}}, b_mag};
            mcand_q <= a_mag;
          end
        end
        CALC: begin
          acc_q <= is_div ? div_nxt : mul_nxt;
          cnt_q <= cnt_q + 1'b1;
        end
        FIN: begin
          if (done_o) res_q <= fin_val;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed and randomized bench for mdu_sequencer against an arithmetic reference model.
module tb_mdu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_fail = 0;

  mdu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RISC-V M-extension semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick(input int zero_bias);
    int sel;
    sel = $urandom_range(0, 7 + zero_bias);
    case (sel)
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0001;
      3, 4, 5, 6, 7: return $urandom;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after an active edge; returns with the unit back in IDLE and start_i low.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit sok);
    sok = 1'b1; lat = 0; res = '0;
    funct3_i = f; op_a_i = a; op_b_i = b; start_i = 1'b1;
    #1;
    if (stall_o !== 1'b1) sok = 1'b0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge clk); #1;
      op_a_i = $urandom; op_b_i = $urandom;
      if (done_o === 1'b1) begin
        lat = k; res = result_o;
        if (stall_o !== 1'b0) sok = 1'b0;
      end else if (stall_o !== 1'b1 || busy_o !== 1'b1) begin
        sok = 1'b0;
      end
    end
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] got;
    int          lat;
    bit          sok;
    run_op(f, a, b, got, lat, sok);
    chk({tag, "_res"}, got, exp_res);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_stall"}, {31'd0, sok}, 32'd1);
    chk({tag, "_idle_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_hold"}, result_o, exp_res);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b, prev;
    bit          saw_done;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    start_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("idle_flush_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    chk("idle_flush_busy", {31'd0, busy_o}, 32'd0);
    start_i = 1'b0; flush_i = 1'b0;
    @(posedge clk); #1;

    op_check("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    op_check("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    op_check("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    op_check("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    op_check("div_-7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    op_check("rem_-7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    op_check("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    op_check("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    op_check("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    op_check("remu_5_0", 3'b111, 32'd5, 32'd0, 32'd5, 2);
    op_check("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    op_check("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
    op_check("mul_by_0", 3'b000, 32'h1234_5678, 32'd0, 32'd0, 34);

    // Flush in the middle of a multiply, then a fresh DIVU two cycles later
    prev = result_o;
    saw_done = 1'b0;
    funct3_i = 3'b000; op_a_i = 32'd9; op_b_i = 32'd9; start_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) saw_done = 1'b1;
    end
    flush_i = 1'b1;
    #1;
    if (done_o === 1'b1) saw_done = 1'b1;
    @(posedge clk); #1;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_done", {31'd0, done_o | saw_done}, 32'd0);
    chk("flush_result", result_o, prev);
    flush_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    op_check("divu_after_flush", 3'b101, 32'd1000, 32'd33, 32'd30, 34);

    // Reset in the middle of a divide
    funct3_i = 3'b100; op_a_i = 32'd77; op_b_i = 32'd5; start_i = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    start_i = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_done", {31'd0, done_o}, 32'd0);
    chk("midrst_result", result_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op_check("div_after_rst", 3'b100, 32'd77, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 34);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick(0);
      b = pick(2);
      op_check($sformatf("rnd%0d_f%0d_%h_%h", i, f, a, b), f, a, b, ref_mdu(f, a, b), ref_lat(f, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
